// File: rtl/relu_pkg.sv
// Shared mode encoding for the multi-lane ReLU activation stream.
package relu_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_BYPASS = 2'd0;
    localparam mode_t MODE_RELU   = 2'd1;
    localparam mode_t MODE_LEAKY  = 2'd2;
    localparam mode_t MODE_CLAMP  = 2'd3;

endpackage

// File: rtl/relu_lane.sv
// Single-element combinational activation: bypass, ReLU, leaky ReLU or clamp.
module relu_lane
    import relu_pkg::*;
#(
    parameter int DATA_W     = 6,
    parameter int LEAK_SHIFT = 2,
    parameter int CLAMP_MAX  = 31
) (
    input  logic signed [DATA_W-1:0] x,
    input  mode_t                    mode,
    output logic signed [DATA_W-1:0] y
);

    localparam logic signed [DATA_W-1:0] CMAX = DATA_W'(CLAMP_MAX);

    logic neg;
    assign neg = x[DATA_W-1];

    always_comb begin
        y = x;
        case (mode)
            MODE_RELU:  if (neg) y = '0;
            // Arithmetic shift floors, so the most-negative input stays in range.
            MODE_LEAKY: if (neg) y = x >>> LEAK_SHIFT;
            MODE_CLAMP: begin
                if (neg)            y = '0;
                else if (x > CMAX)  y = CMAX;
            end
            default:    y = x;
        endcase
    end

endmodule

// File: rtl/relu_stream.sv
// Two-stage valid/ready activation pipeline over LANES elements per beat.
// Optional changed-lane counter on clip_count when RELU_STREAM_STATS_EN is defined.
module relu_stream
    import relu_pkg::*;
#(
    parameter int DATA_W     = 6,
    parameter int LANES      = 4,
    parameter int LEAK_SHIFT = 2,
    parameter int CLAMP_MAX  = 31
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   in_data,
    input  mode_t                     in_mode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*DATA_W-1:0]   out_data
`ifdef RELU_STREAM_STATS_EN
    ,
    output logic [15:0]               clip_count
`endif
);

    logic [LANES-1:0][DATA_W-1:0] in_lanes, act_lanes, s1_data, s2_data;
    logic [LANES-1:0]             act_chg, s1_chg, s2_chg;
    logic                         s1_vld, s2_vld;
    logic                         s1_load, s2_load;

    assign in_lanes = in_data;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        relu_lane #(
            .DATA_W    (DATA_W),
            .LEAK_SHIFT(LEAK_SHIFT),
            .CLAMP_MAX (CLAMP_MAX)
        ) u_lane (
            .x   (in_lanes[g]),
            .mode(in_mode),
            .y   (act_lanes[g])
        );
        assign act_chg[g] = (act_lanes[g] != in_lanes[g]);
    end

    // A stage may load when it is empty or its contents leave this cycle.
    assign s2_load   = !s2_vld || out_ready;
    assign s1_load   = !s1_vld || s2_load;
    assign in_ready  = s1_load;
    assign out_valid = s2_vld;
    assign out_data  = s2_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s2_vld  <= 1'b0;
            s1_data <= '0;
            s2_data <= '0;
            s1_chg  <= '0;
            s2_chg  <= '0;
        end else begin
            if (s1_load) begin
                s1_vld <= in_valid;
                if (in_valid) begin
                    s1_data <= act_lanes;
                    s1_chg  <= act_chg;
                end
            end
            if (s2_load) begin
                s2_vld <= s1_vld;
                if (s1_vld) begin
                    s2_data <= s1_data;
                    s2_chg  <= s1_chg;
                end
            end
        end
    end

`ifdef RELU_STREAM_STATS_EN
    localparam int CW = $clog2(LANES + 1);

    logic [CW-1:0] n_chg;
    logic [16:0]   clip_sum;

    always_comb begin
        n_chg = '0;
        for (int i = 0; i < LANES; i++) n_chg = n_chg + CW'(s2_chg[i]);
        clip_sum = {1'b0, clip_count} + 17'(n_chg);
    end

    always_ff @(posedge clk) begin
        if (rst)
            clip_count <= '0;
        else if (out_valid && out_ready)
            clip_count <= clip_sum[16] ? 16'hFFFF : clip_sum[15:0];
    end
`endif

endmodule
